elastic_skid_buffer: RTL and testbench
======================================

ELASTIC_SKID_BUFFER -- requirements
Module: elastic_skid_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, storage entries; legal values are powers of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port din  input  DATA_WIDTH  upstream payload.
REQ-006 SHALL have port val_in  input  1  upstream valid.
REQ-007 SHALL have port ready_upward  output  1  buffer can accept this cycle.
REQ-008 SHALL have port dout  output  DATA_WIDTH  downstream payload.
REQ-009 SHALL have port val_out  output  1  downstream valid.
REQ-010 SHALL have port ready_downward  input  1  downstream ready.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-012 SHALL accept a word on any rising edge where val_in=1 and ready_upward=1 (push).
REQ-013 SHALL retire a word on any rising edge where val_out=1 and ready_downward=1 (pop).
REQ-014 SHALL store words in a circular array with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 without gap.
REQ-015 SHALL drive ready_upward = (count != DEPTH), decoded from registers only, never from ready_downward.
REQ-016 SHALL drive val_out = (count != 0) and dout = entry at rd_ptr (buffered path).
REQ-017 SHALL present a word pushed into an empty buffer on dout/val_out the cycle after the push (1-cycle latency, buffered path).
REQ-018 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push+pop or neither.
REQ-019 SHALL, when full with ready_downward=1, pop this cycle but refuse the push (ready_upward=0); ready_upward rises the following cycle.
REQ-020 SHALL, when empty, ignore ready_downward; no pop, no underflow of count or rd_ptr.
REQ-021 SHALL hold dout and val_out stable while val_out=1 and ready_downward=0 (no payload change under backpressure).
REQ-022 SHALL preserve strict FIFO order; no word dropped or duplicated under any val_in/ready_downward pattern.
REQ-023 SHALL ignore din whenever val_in=0 or ready_upward=0.

Reset
REQ-024 SHALL, on reset=0, asynchronously clear rd_ptr, wr_ptr and count to 0, giving val_out=0, ready_upward=1, count=0.
REQ-025 SHALL drive dout=0 while count=0 after reset; storage array contents are not reset.
REQ-026 SHALL, on reset asserted mid-transfer, discard all stored words; first word after release starts from an empty buffer.
REQ-027 SHALL accept no push on the first rising edge coinciding with reset deassertion.

Configuration
REQ-028 SHALL, with macro ELASTIC_BYPASS_EN defined, add a cut-through path: when count=0 and ready_downward=1, dout=din, val_out=val_in, ready_upward=1, and the word is consumed without being stored (0-cycle latency, count unchanged).
REQ-029 SHALL, with ELASTIC_BYPASS_EN defined and count=0 and ready_downward=0, store the word per REQ-012 (skid behaviour).
REQ-030 SHALL, without ELASTIC_BYPASS_EN, have no combinational din->dout or val_in->val_out path; behaviour per REQ-016/017 only.

Verification
REQ-031 SHALL cover: reset=0 for 3 cycles with val_in=1 -> val_out=0, ready_upward=1, count=0 throughout, dout=0.
REQ-032 SHALL cover: DEPTH=4, ready_downward=0, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> count=4, ready_upward=0 after 4th, 0x55 not accepted, dout=0x11 held.
REQ-033 SHALL cover: full buffer, ready_downward=1 and val_in=1 same cycle -> pop 0x11, push refused, count=3; next cycle push 0x55 accepted, output order 0x22,0x33,0x44,0x55.
REQ-034 SHALL cover: 20 words 0..19 with random val_in and ready_downward (seeded) -> output exactly 0..19 in order, wr_ptr wraps 5 times, count never exceeds 4.
REQ-035 SHALL cover: ELASTIC_BYPASS_EN defined, empty, ready_downward=1, val_in=1, din=0xA5 -> dout=0xA5, val_out=1 same cycle, count stays 0; undefined -> dout=0xA5 one cycle later, count pulses 1.
REQ-036 SHALL cover: count=3, reset pulsed low mid-cycle (asynchronous) -> val_out=0, count=0 immediately, before next clk edge.

Source files
------------

// File: rtl/elastic_skid_buffer.sv
// elastic_skid_buffer
//   Circular-array elastic buffer between a valid/ready producer and consumer.
//   Output is registered by default: a word pushed into an empty buffer shows
//   up on dout/val_out one cycle later. ready_upward depends only on occupancy
//   and never on ready_downward, so there is no combinational ready path.
//
//   Optional build macro: ELASTIC_BYPASS_EN
//     When it is defined, an empty buffer with ready_downward=1 forwards din/val_in
//     straight to dout/val_out. That word is consumed without being stored.
//     When the buffer is empty and ready_downward=0, the word is stored as usual (skid).
//
// Parameters
//   DATA_WIDTH     payload width
//   DEPTH          storage entries, power of two, 2..256
// Ports
//   clk            clock, rising edge
//   reset          asynchronous reset, active low
//   din            upstream payload
//   val_in         upstream valid
//   ready_upward   buffer can accept a word this cycle
//   dout           downstream payload (0 while empty)
//   val_out        downstream valid
//   ready_downward downstream ready
//   count          occupancy, 0..DEPTH

module elastic_skid_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        din,
   input  logic                         val_in,
   output logic                         ready_upward,
   output logic [DATA_WIDTH-1:0]        dout,
   output logic                         val_out,
   input  logic                         ready_downward,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic                  empty;
   logic                  full;
   logic                  bypass;
   logic                  push;
   logic                  pop;

   assign empty        = (count == '0);
   assign full         = (count == CNT_FULL);
   assign ready_upward = ~full;

`ifdef ELASTIC_BYPASS_EN
   // Cut-through is held off while reset is asserted so that the outputs
   // stay idle during reset, even with upstream traffic present.
   assign bypass  = reset & empty & ready_downward;
   assign val_out = bypass ? val_in : ~empty;
   assign dout    = bypass ? din : (empty ? '0 : mem[rd_ptr]);
`else
   assign bypass  = 1'b0;
   assign val_out = ~empty;
   // Storage is not reset, so the output is forced to 0 while empty.
   assign dout    = empty ? '0 : mem[rd_ptr];
`endif

   // A bypassed word goes straight through and is never written.
   assign push = val_in & ready_upward & ~bypass;
   assign pop  = val_out & ready_downward & ~empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: tb/tb_elastic_skid_buffer.sv
module tb_elastic_skid_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] din = '0;
   logic          val_in = 1'b0;
   logic          ready_downward = 1'b0;
   logic          ready_upward;
   logic [DW-1:0] dout;
   logic          val_out;
   logic [CW-1:0] count;

   int            vectors = 0;
   int            errors  = 0;
   int            rx_cnt  = 0;
   logic [DW-1:0] exp_q[$];

   int            m_sz;
   logic          m_byp;
   logic          m_val;
   logic [DW-1:0] m_dout;

   always #5 clk = ~clk;

   elastic_skid_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .din            (din),
      .val_in         (val_in),
      .ready_upward   (ready_upward),
      .dout           (dout),
      .val_out        (val_out),
      .ready_downward (ready_downward),
      .count          (count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the queue holds the words in flight, and its size is the occupancy.
   // The driver appends accepted words at the clock edge.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, output logic ok);
      @(negedge clk);
      val_in = v;
      din = d;
      ready_downward = r;
      ok = reset && v && (exp_q.size() < DEPTH);
`ifdef ELASTIC_BYPASS_EN
      if (exp_q.size() == 0 && r)
         ok = 1'b0;
`endif
      @(posedge clk);
      if (ok)
         exp_q.push_back(d);
   endtask

   // Monitor: checks the outputs just before each rising edge, and retires
   // expected words on a handshake.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         m_sz  = exp_q.size();
         m_byp = 1'b0;
`ifdef ELASTIC_BYPASS_EN
         m_byp = reset && (m_sz == 0) && ready_downward;
`endif
         if (m_byp) begin
            m_val  = val_in;
            m_dout = din;
         end else begin
            m_val  = (m_sz != 0);
            m_dout = (m_sz != 0) ? exp_q[0] : '0;
         end
         chk("mon_val_out", val_out, m_val);
         chk("mon_dout", dout, m_dout);
         chk("mon_ready_upward", ready_upward, (m_sz != DEPTH));
         chk("mon_count", count, m_sz);
         if (m_val && ready_downward) begin
            rx_cnt++;
            if (!m_byp)
               void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic ok;
      int   nxt;
      int   rx_base;
      void'($urandom(32'h5EED_1234));

      // Reset is held for 3 cycles with upstream traffic present. The monitor checks the idle outputs.
      repeat (3) drive(1'b1, 32'hDEAD_BEEF, 1'b1, ok);
      #1;
      chk("rst_count", count, 0);
      chk("rst_val_out", val_out, 0);
      chk("rst_ready_upward", ready_upward, 1);
      chk("rst_dout", dout, 0);
      @(negedge clk);
      val_in = 1'b0;
      reset = 1'b1;

      // Fill the buffer while the downstream stalls. The fifth word must be refused.
      drive(1'b1, 32'h11, 1'b0, ok);
      drive(1'b1, 32'h22, 1'b0, ok);
      drive(1'b1, 32'h33, 1'b0, ok);
      drive(1'b1, 32'h44, 1'b0, ok);
      drive(1'b1, 32'h55, 1'b0, ok);
      #1;
      chk("full_count", count, 4);
      chk("full_ready_upward", ready_upward, 0);
      chk("full_dout_held", dout, 32'h11);

      // Buffer is full and a pop occurs: the push is refused. On the next cycle 0x55 is accepted.
      drive(1'b1, 32'h55, 1'b1, ok);
      #1;
      chk("full_pop_count", count, 3);
      chk("full_pop_ready_up", ready_upward, 1);
      drive(1'b1, 32'h55, 1'b1, ok);
      #1;
      chk("refill_count", count, 3);
      repeat (5) drive(1'b0, 32'h0, 1'b1, ok);
      chk("drained_q", exp_q.size(), 0);

      // Push 20 sequential words with random valid and ready patterns.
      nxt = 0;
      rx_base = rx_cnt;
      for (int c = 0; c < 600 && nxt < 20; c++) begin
         drive(1'($urandom_range(0, 1)), DW'(nxt), 1'($urandom_range(0, 1)), ok);
         if (ok)
            nxt++;
         #1;
         chk("seq_count_le_depth", (count <= CW'(DEPTH)), 1);
      end
      chk("seq_all_pushed", nxt, 20);
      repeat (6) drive(1'b0, 32'h0, 1'b1, ok);
      chk("seq_rx_total", rx_cnt - rx_base, 20);

      // A single word enters an empty buffer with the downstream ready.
      drive(1'b1, 32'hA5, 1'b1, ok);
      #1;
`ifdef ELASTIC_BYPASS_EN
      chk("byp_count", count, 0);
`else
      chk("lat1_dout", dout, 32'hA5);
      chk("lat1_val_out", val_out, 1);
      chk("lat1_count", count, 1);
`endif
      repeat (2) drive(1'b0, 32'h0, 1'b1, ok);

      // Random traffic, in two phases with different backpressure bias.
      for (int c = 0; c < 400; c++)
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0), ok);
      for (int c = 0; c < 400; c++)
         drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0), ok);
      repeat (6) drive(1'b0, 32'h0, 1'b1, ok);
      chk("rand_drained", count, 0);

      // Asynchronous reset is pulsed in the middle of a cycle with 3 words stored.
      drive(1'b1, 32'hC1, 1'b0, ok);
      drive(1'b1, 32'hC2, 1'b0, ok);
      drive(1'b1, 32'hC3, 1'b0, ok);
      #1;
      chk("pre_rst_count", count, 3);
      @(negedge clk);
      val_in = 1'b0;
      ready_downward = 1'b0;
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_val_out", val_out, 0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 32'h77, 1'b0, ok);
      #1;
      chk("post_rst_count", count, 1);
      chk("post_rst_dout", dout, 32'h77);
      repeat (3) drive(1'b0, 32'h0, 1'b1, ok);
      chk("final_empty", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
